axi_err_inject: RTL and testbench

- Inline AXI4 (+ATOP) error injector between an upstream manager (slv port) and a downstream subordinate (mst port), configured through a register interface.
- When armed, it replaces the response of exactly one selected write and/or read transaction with a programmed SLVERR or DECERR code.
- It is the stimulus source for the bus error monitors: they observe erroneous responses, this block produces them.
- All AXI channels pass through with zero latency; only the B/R resp field of the targeted transaction is altered.

---
 rtl/axi_err_inject.sv | 369 ++++++++++++++++++++++++++++++++++++
 tb/tb_axi_err_inject.sv | 364 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_err_inject.sv
// Inline AXI4 (+ATOP) error injector: passes every channel through untouched and
// replaces the B/R resp of one selected write and/or read transaction with SLVERR/DECERR.

package axi_err_inject_pkg;

  localparam int unsigned AxiAddrW  = 32;
  localparam int unsigned AxiIdW    = 2;
  localparam int unsigned AxiDataW  = 32;
  localparam int unsigned AtopRResp = 5;

  typedef enum logic [1:0] {
    ENG_IDLE   = 2'd0,
    ENG_ARMED  = 2'd1,
    ENG_WAIT   = 2'd2,
    ENG_INJECT = 2'd3
  } eng_state_e;

  typedef struct packed {
    logic [AxiIdW-1:0]   id;
    logic [AxiAddrW-1:0] addr;
    logic [7:0]          len;
    logic [5:0]          atop;
  } aw_chan_t;

  typedef struct packed {
    logic [AxiDataW-1:0]   data;
    logic [AxiDataW/8-1:0] strb;
    logic                  last;
  } w_chan_t;

  typedef struct packed {
    logic [AxiIdW-1:0] id;
    logic [1:0]        resp;
  } b_chan_t;

  typedef struct packed {
    logic [AxiIdW-1:0]   id;
    logic [AxiAddrW-1:0] addr;
    logic [7:0]          len;
  } ar_chan_t;

  typedef struct packed {
    logic [AxiIdW-1:0]   id;
    logic [AxiDataW-1:0] data;
    logic [1:0]          resp;
    logic                last;
  } r_chan_t;

  typedef struct packed {
    aw_chan_t aw;
    logic     aw_valid;
    w_chan_t  w;
    logic     w_valid;
    logic     b_ready;
    ar_chan_t ar;
    logic     ar_valid;
    logic     r_ready;
  } axi_req_t;

  typedef struct packed {
    logic    aw_ready;
    logic    w_ready;
    b_chan_t b;
    logic    b_valid;
    logic    ar_ready;
    r_chan_t r;
    logic    r_valid;
  } axi_rsp_t;

  typedef struct packed {
    logic [31:0] addr;
    logic        write;
    logic [31:0] wdata;
    logic        valid;
  } reg_req_t;

  typedef struct packed {
    logic [31:0] rdata;
    logic        error;
    logic        ready;
  } reg_rsp_t;

endpackage

module axi_err_inject #(
  parameter int unsigned AddrWidth      = 32,
  parameter int unsigned IdWidth        = 2,
  parameter int unsigned MaxOutstanding = 8,
  parameter type         axi_req_t      = axi_err_inject_pkg::axi_req_t,
  parameter type         axi_rsp_t      = axi_err_inject_pkg::axi_rsp_t,
  parameter type         reg_req_t      = axi_err_inject_pkg::reg_req_t,
  parameter type         reg_rsp_t      = axi_err_inject_pkg::reg_rsp_t
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  axi_req_t   slv_req_i,
  output axi_rsp_t   slv_rsp_o,
  output axi_req_t   mst_req_o,
  input  axi_rsp_t   mst_rsp_i,
  input  reg_req_t   reg_req_i,
  output reg_rsp_t   reg_rsp_o,
  output logic [1:0] inj_irq_o
);

  import axi_err_inject_pkg::eng_state_e;
  import axi_err_inject_pkg::ENG_IDLE;
  import axi_err_inject_pkg::ENG_ARMED;
  import axi_err_inject_pkg::ENG_WAIT;
  import axi_err_inject_pkg::ENG_INJECT;
  import axi_err_inject_pkg::AtopRResp;

  localparam int unsigned NumIds = 2 ** IdWidth;
  localparam int unsigned CntW   = $clog2(MaxOutstanding + 1);

  localparam logic [31:0] AddrCtrl      = 32'h00;
  localparam logic [31:0] AddrMatchAddr = 32'h04;
  localparam logic [31:0] AddrMatchMask = 32'h08;
  localparam logic [31:0] AddrStatus    = 32'h0C;
  localparam logic [31:0] AddrInjCount  = 32'h10;

  // Channel events
  logic               aw_hs, b_hs, ar_hs, r_hs;
  logic               b_valid, b_ready, r_valid, r_ready, r_last, aw_atop_r;
  logic [IdWidth-1:0] aw_id, b_id, ar_id, r_id;
  logic               aw_match, ar_match;

  // Configuration / status
  logic [31:0]  match_addr_q, match_mask_q;
  logic [1:0]   wcode_q, rcode_q;
  logic         w_done_q, r_done_q;
  logic [15:0]  w_inj_cnt_q, r_inj_cnt_q;
  logic         reg_we, ctrl_we, maddr_we, mmask_we, status_we, count_we;
  logic         arm_w, arm_r, abort;

  // Outstanding counters
  logic [CntW-1:0] wcnt_q [NumIds];
  logic [CntW-1:0] wcnt_d [NumIds];
  logic [CntW-1:0] rcnt_q [NumIds];
  logic [CntW-1:0] rcnt_d [NumIds];

  // Engines
  eng_state_e         w_state_q, w_state_d, r_state_q, r_state_d;
  logic [IdWidth-1:0] w_tgt_q, w_tgt_d, r_tgt_q, r_tgt_d;
  logic [CntW-1:0]    w_skip_q, w_skip_d, r_skip_q, r_skip_d;
  logic               w_hit, w_fire, r_hit, r_fire;
  logic               r_trig_ar, r_trig_aw;
  logic [IdWidth-1:0] r_trig_id;

  assign b_valid   = mst_rsp_i.b_valid;
  assign b_ready   = slv_req_i.b_ready;
  assign r_valid   = mst_rsp_i.r_valid;
  assign r_ready   = slv_req_i.r_ready;
  assign r_last    = mst_rsp_i.r.last;
  assign aw_hs     = slv_req_i.aw_valid & mst_rsp_i.aw_ready;
  assign ar_hs     = slv_req_i.ar_valid & mst_rsp_i.ar_ready;
  assign b_hs      = b_valid & b_ready;
  assign r_hs      = r_valid & r_ready;
  assign aw_id     = slv_req_i.aw.id[IdWidth-1:0];
  assign ar_id     = slv_req_i.ar.id[IdWidth-1:0];
  assign b_id      = mst_rsp_i.b.id[IdWidth-1:0];
  assign r_id      = mst_rsp_i.r.id[IdWidth-1:0];
  assign aw_atop_r = slv_req_i.aw.atop[AtopRResp];

  assign aw_match = (slv_req_i.aw.addr[AddrWidth-1:0] & match_mask_q[AddrWidth-1:0])
                 == (match_addr_q[AddrWidth-1:0] & match_mask_q[AddrWidth-1:0]);
  assign ar_match = (slv_req_i.ar.addr[AddrWidth-1:0] & match_mask_q[AddrWidth-1:0])
                 == (match_addr_q[AddrWidth-1:0] & match_mask_q[AddrWidth-1:0]);

  assign r_trig_ar = ar_hs & ar_match;
  assign r_trig_aw = aw_hs & aw_atop_r & aw_match;
  assign r_trig_id = r_trig_ar ? ar_id : aw_id;

  assign reg_we    = reg_req_i.valid & reg_req_i.write;
  assign ctrl_we   = reg_we & (reg_req_i.addr == AddrCtrl);
  assign maddr_we  = reg_we & (reg_req_i.addr == AddrMatchAddr);
  assign mmask_we  = reg_we & (reg_req_i.addr == AddrMatchMask);
  assign status_we = reg_we & (reg_req_i.addr == AddrStatus);
  assign count_we  = reg_we & (reg_req_i.addr == AddrInjCount);
  assign arm_w     = ctrl_we & reg_req_i.wdata[0];
  assign arm_r     = ctrl_we & reg_req_i.wdata[1];
  assign abort     = ctrl_we & reg_req_i.wdata[6];

  assign mst_req_o = slv_req_i;
  assign inj_irq_o = {r_done_q, w_done_q};

  always_comb begin
    slv_rsp_o = mst_rsp_i;
    if (w_hit) slv_rsp_o.b.resp = wcode_q;
    if (r_hit) slv_rsp_o.r.resp = rcode_q;
  end

  always_comb begin
    // NOTE: every output of a combinational block gets a default first so no path infers a latch.
    reg_rsp_o       = '0;
    reg_rsp_o.ready = 1'b1;
    unique case (reg_req_i.addr)
      AddrCtrl:      reg_rsp_o.rdata = '0;
      AddrMatchAddr: reg_rsp_o.rdata = match_addr_q;
      AddrMatchMask: reg_rsp_o.rdata = match_mask_q;
      AddrStatus:    reg_rsp_o.rdata = {26'd0, r_done_q, w_done_q, r_state_q, w_state_q};
      AddrInjCount:  reg_rsp_o.rdata = {r_inj_cnt_q, w_inj_cnt_q};
      default:       reg_rsp_o.error = 1'b1;
    endcase
  end

  // Simultaneous request and completion on the same ID cancel out.
  always_comb begin
    for (int i = 0; i < NumIds; i++) begin
      wcnt_d[i] = wcnt_q[i]
                + CntW'(aw_hs && (aw_id == IdWidth'(i)))
                - CntW'(b_hs && (b_id == IdWidth'(i)));
      rcnt_d[i] = rcnt_q[i]
                + CntW'(ar_hs && (ar_id == IdWidth'(i)))
                + CntW'(aw_hs && aw_atop_r && (aw_id == IdWidth'(i)))
                - CntW'(r_hs && r_last && (r_id == IdWidth'(i)));
    end
  end

  always_comb begin
    w_state_d = w_state_q;
    w_tgt_d   = w_tgt_q;
    w_skip_d  = w_skip_q;
    w_hit     = 1'b0;
    w_fire    = 1'b0;
    unique case (w_state_q)
      ENG_IDLE: if (arm_w) w_state_d = ENG_ARMED;
      ENG_ARMED: begin
        if (aw_hs && aw_match) begin
          w_tgt_d   = aw_id;
          w_state_d = ENG_WAIT;
          if (wcnt_q[aw_id] == '0) begin
            // Nothing older on this ID: a same-cycle B already is the target.
            w_skip_d = '0;
            if (b_valid && (b_id == aw_id)) begin
              w_hit = 1'b1;
              if (b_ready) begin
                w_fire    = 1'b1;
                w_state_d = ENG_IDLE;
              end
            end
          end else begin
            w_skip_d = wcnt_q[aw_id] - CntW'(b_hs && (b_id == aw_id));
          end
        end
      end
      ENG_WAIT: begin
        if (b_valid && (b_id == w_tgt_q)) begin
          if (w_skip_q == '0) begin
            w_hit = 1'b1;
            if (b_ready) begin
              w_fire    = 1'b1;
              w_state_d = ENG_IDLE;
            end
          end else if (b_ready) begin
            w_skip_d = w_skip_q - CntW'(1);
          end
        end
      end
      default: w_state_d = ENG_IDLE;
    endcase
    if (abort) w_state_d = ENG_IDLE;
  end

  always_comb begin
    r_state_d = r_state_q;
    r_tgt_d   = r_tgt_q;
    r_skip_d  = r_skip_q;
    r_hit     = 1'b0;
    r_fire    = 1'b0;
    unique case (r_state_q)
      ENG_IDLE: if (arm_r) r_state_d = ENG_ARMED;
      ENG_ARMED: begin
        if (r_trig_ar || r_trig_aw) begin
          r_tgt_d   = r_trig_id;
          r_state_d = ENG_WAIT;
          if (rcnt_q[r_trig_id] == '0) begin
            r_skip_d = '0;
            if (r_valid && (r_id == r_trig_id)) begin
              r_hit = 1'b1;
              if (r_ready) begin
                r_fire    = r_last;
                r_state_d = r_last ? ENG_IDLE : ENG_INJECT;
              end
            end
          end else begin
            r_skip_d = rcnt_q[r_trig_id] - CntW'(r_hs && r_last && (r_id == r_trig_id));
          end
        end
      end
      ENG_WAIT: begin
        if (r_valid && (r_id == r_tgt_q)) begin
          if (r_skip_q == '0) begin
            r_hit = 1'b1;
            if (r_ready) begin
              r_fire    = r_last;
              r_state_d = r_last ? ENG_IDLE : ENG_INJECT;
            end
          end else if (r_ready && r_last) begin
            r_skip_d = r_skip_q - CntW'(1);
          end
        end
      end
      ENG_INJECT: begin
        if (r_valid && (r_id == r_tgt_q)) begin
          r_hit = 1'b1;
          if (r_ready && r_last) begin
            r_fire    = 1'b1;
            r_state_d = ENG_IDLE;
          end
        end
      end
      default: r_state_d = ENG_IDLE;
    endcase
    if (abort) r_state_d = ENG_IDLE;
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      match_addr_q <= '0;
      match_mask_q <= '0;
      wcode_q      <= '0;
      rcode_q      <= '0;
      w_done_q     <= 1'b0;
      r_done_q     <= 1'b0;
      w_inj_cnt_q  <= '0;
      r_inj_cnt_q  <= '0;
      w_state_q    <= ENG_IDLE;
      r_state_q    <= ENG_IDLE;
      w_tgt_q      <= '0;
      r_tgt_q      <= '0;
      w_skip_q     <= '0;
      r_skip_q     <= '0;
      // NOTE: the counter arrays are small flop banks that must start at zero, so they are reset like any register.
      wcnt_q       <= '{default: '0};
      rcnt_q       <= '{default: '0};
    end else begin
      if (ctrl_we) begin
        wcode_q <= {1'b1, reg_req_i.wdata[2]};
        rcode_q <= {1'b1, reg_req_i.wdata[4]};
      end
      if (maddr_we) match_addr_q <= reg_req_i.wdata;
      if (mmask_we) match_mask_q <= reg_req_i.wdata;

      if (w_fire)                              w_done_q <= 1'b1;
      else if (status_we && reg_req_i.wdata[4]) w_done_q <= 1'b0;
      if (r_fire)                              r_done_q <= 1'b1;
      else if (status_we && reg_req_i.wdata[5]) r_done_q <= 1'b0;

      if (count_we) begin
        w_inj_cnt_q <= '0;
        r_inj_cnt_q <= '0;
      end else begin
        if (w_fire && (w_inj_cnt_q != 16'hFFFF)) w_inj_cnt_q <= w_inj_cnt_q + 16'd1;
        if (r_fire && (r_inj_cnt_q != 16'hFFFF)) r_inj_cnt_q <= r_inj_cnt_q + 16'd1;
      end

      w_state_q <= w_state_d;
      r_state_q <= r_state_d;
      w_tgt_q   <= w_tgt_d;
      r_tgt_q   <= r_tgt_d;
      w_skip_q  <= w_skip_d;
      r_skip_q  <= r_skip_d;
      wcnt_q    <= wcnt_d;
      rcnt_q    <= rcnt_d;
    end
  end

endmodule

// File: tb/tb_axi_err_inject.sv
// Self-checking bench for axi_err_inject: acts as both manager and subordinate and
// scores every response beat the manager sees against a queue of expected beats.

module tb_axi_err_inject;
  import axi_err_inject_pkg::*;

  localparam logic [31:0] CTRL = 32'h00, MADDR = 32'h04, MMASK = 32'h08;
  localparam logic [31:0] STAT = 32'h0C, ICNT = 32'h10;

  logic       clk_i = 1'b0;
  logic       rst_ni;
  axi_req_t   slv_req, mst_req;
  axi_rsp_t   slv_rsp, mst_rsp;
  reg_req_t   reg_req;
  reg_rsp_t   reg_rsp;
  logic [1:0] irq;

  typedef struct {
    logic [1:0]  id;
    logic [1:0]  resp;
    logic [31:0] data;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;

  axi_err_inject dut (
    .clk_i     (clk_i),
    .rst_ni    (rst_ni),
    .slv_req_i (slv_req),
    .slv_rsp_o (slv_rsp),
    .mst_req_o (mst_req),
    .mst_rsp_i (mst_rsp),
    .reg_req_i (reg_req),
    .reg_rsp_o (reg_rsp),
    .inj_irq_o (irq)
  );

  always #5 clk_i = ~clk_i;

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic reg_access(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                            output logic [31:0] rdata, output logic err);
    reg_req.valid = 1'b1;
    reg_req.write = wr;
    reg_req.addr  = addr;
    reg_req.wdata = wdata;
    @(negedge clk_i);
    rdata = reg_rsp.rdata;
    err   = reg_rsp.error;
    step();
    reg_req = '0;
  endtask

  task automatic reg_wr(input logic [31:0] addr, input logic [31:0] wdata);
    logic [31:0] d;
    logic        e;
    reg_access(1'b1, addr, wdata, d, e);
  endtask

  task automatic reg_rd(input logic [31:0] addr, output logic [31:0] d, output logic e);
    reg_access(1'b0, addr, 32'h0, d, e);
  endtask

  task automatic send_aw(input logic [1:0] id, input logic [31:0] addr, input logic [5:0] atop);
    slv_req.aw.id   = id;
    slv_req.aw.addr = addr;
    slv_req.aw.atop = atop;
    slv_req.aw_valid = 1'b1;
    step();
    slv_req.aw_valid = 1'b0;
  endtask

  task automatic send_ar(input logic [1:0] id, input logic [31:0] addr, input logic [7:0] len);
    slv_req.ar.id   = id;
    slv_req.ar.addr = addr;
    slv_req.ar.len  = len;
    slv_req.ar_valid = 1'b1;
    step();
    slv_req.ar_valid = 1'b0;
  endtask

  // Subordinate always answers OKAY; any other resp seen upstream was injected.
  task automatic b_beat(input logic [1:0] id, output logic [1:0] resp);
    mst_rsp.b.id    = id;
    mst_rsp.b.resp  = 2'b00;
    mst_rsp.b_valid = 1'b1;
    slv_req.b_ready = 1'b1;
    @(negedge clk_i);
    resp = slv_rsp.b.resp;
    step();
    mst_rsp.b_valid = 1'b0;
    slv_req.b_ready = 1'b0;
  endtask

  task automatic r_beat(input logic [1:0] id, input logic [31:0] data, input logic last,
                        output logic [1:0] resp, output logic [31:0] data_seen);
    mst_rsp.r.id    = id;
    mst_rsp.r.data  = data;
    mst_rsp.r.resp  = 2'b00;
    mst_rsp.r.last  = last;
    mst_rsp.r_valid = 1'b1;
    slv_req.r_ready = 1'b1;
    @(negedge clk_i);
    resp      = slv_rsp.r.resp;
    data_seen = slv_rsp.r.data;
    step();
    mst_rsp.r_valid = 1'b0;
    slv_req.r_ready = 1'b0;
  endtask

  task automatic test_reset();
    logic [31:0] d;
    logic        e;
    total++; if (irq !== 2'b00) begin bad++; $display("FAIL reset_irq: got %b want 00", irq); end
    reg_rd(STAT, d, e);
    total++; if (d !== 32'h0 || e !== 1'b0) begin bad++; $display("FAIL reset_status: got %h err %b want 0", d, e); end
    reg_rd(ICNT, d, e);
    total++; if (d !== 32'h0) begin bad++; $display("FAIL reset_count: got %h want 0", d); end
    reg_rd(MADDR, d, e);
    total++; if (d !== 32'h0) begin bad++; $display("FAIL reset_maddr: got %h want 0", d); end
    reg_wr(CTRL, 32'h0000_0030);
    reg_rd(CTRL, d, e);
    total++; if (d !== 32'h0 || e !== 1'b0) begin bad++; $display("FAIL ctrl_read: got %h err %b want 0", d, e); end
    slv_req.ar.addr = 32'hDEAD_BEE0;
    slv_req.ar.len  = 8'd7;
    slv_req.w.data  = 32'hCAFE_F00D;
    mst_rsp.r.data  = 32'h1234_5678;
    mst_rsp.b.resp  = 2'b01;
    #1;
    total++; if (mst_req !== slv_req) begin bad++; $display("FAIL pass_req: got %h want %h", mst_req, slv_req); end
    total++; if (slv_rsp !== mst_rsp) begin bad++; $display("FAIL pass_rsp: got %h want %h", slv_rsp, mst_rsp); end
    slv_req = '0;
    mst_rsp = '0;
    mst_rsp.aw_ready = 1'b1;
    mst_rsp.ar_ready = 1'b1;
    mst_rsp.w_ready  = 1'b1;
    step();
  endtask

  task automatic test_write_inject();
    logic [31:0] d;
    logic        e;
    logic [1:0]  resp;
    exp_t        x;
    reg_wr(MMASK, 32'h0);
    reg_wr(CTRL, 32'h9);
    reg_rd(STAT, d, e);
    total++; if (d !== 32'h1) begin bad++; $display("FAIL wr_armed: got %h want 1", d); end
    send_aw(2'd1, 32'h40, 6'd0);
    reg_rd(STAT, d, e);
    total++; if (d !== 32'h2) begin bad++; $display("FAIL wr_wait: got %h want 2", d); end
    sb.push_back('{id: 2'd1, resp: 2'b10, data: 32'h0});
    b_beat(2'd1, resp);
    x = sb.pop_front();
    total++; if (resp !== x.resp) begin bad++; $display("FAIL wr_bresp: got %b want %b", resp, x.resp); end
    total++; if (irq !== 2'b01) begin bad++; $display("FAIL wr_irq: got %b want 01", irq); end
    reg_rd(STAT, d, e);
    total++; if (d !== 32'h10) begin bad++; $display("FAIL wr_done: got %h want 10", d); end
    reg_rd(ICNT, d, e);
    total++; if (d !== 32'h1) begin bad++; $display("FAIL wr_count: got %h want 1", d); end
    reg_wr(STAT, 32'h10);
    total++; if (irq !== 2'b00) begin bad++; $display("FAIL wr_w1c: got %b want 00", irq); end
  endtask

  task automatic test_skip();
    logic [31:0] d;
    logic        e;
    logic [1:0]  resp;
    exp_t        x;
    for (int i = 0; i < 3; i++) send_aw(2'd0, 32'h1000 + 32'(i * 16), 6'd0);
    reg_wr(MADDR, 32'h1000);
    reg_wr(MMASK, 32'hFFFF_F000);
    reg_wr(CTRL, 32'h5);
    send_aw(2'd0, 32'h1000, 6'd0);
    for (int i = 0; i < 3; i++) sb.push_back('{id: 2'd0, resp: 2'b00, data: 32'h0});
    sb.push_back('{id: 2'd0, resp: 2'b11, data: 32'h0});
    for (int i = 0; i < 4; i++) begin
      b_beat(2'd0, resp);
      x = sb.pop_front();
      total++; if (resp !== x.resp) begin bad++; $display("FAIL skip_b%0d: got %b want %b", i, resp, x.resp); end
    end
    reg_rd(ICNT, d, e);
    total++; if (d !== 32'h2) begin bad++; $display("FAIL skip_count: got %h want 2", d); end
    reg_wr(ICNT, 32'h1234);
    reg_rd(ICNT, d, e);
    total++; if (d !== 32'h0) begin bad++; $display("FAIL count_clear: got %h want 0", d); end
    reg_wr(STAT, 32'h30);
  endtask

  task automatic test_read_inject();
    logic [31:0] d, ds;
    logic        e;
    logic [1:0]  resp;
    exp_t        x;
    logic [1:0]  ids   [5] = '{2'd2, 2'd3, 2'd2, 2'd2, 2'd2};
    logic        lasts [5] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    reg_wr(MMASK, 32'h0);
    send_ar(2'd3, 32'h500, 8'd0);
    reg_wr(CTRL, 32'h32);
    send_ar(2'd2, 32'h2000, 8'd3);
    for (int i = 0; i < 5; i++)
      sb.push_back('{id: ids[i], resp: (ids[i] == 2'd2) ? 2'b11 : 2'b00, data: 32'hA5A5_0000 + 32'(i)});
    for (int i = 0; i < 5; i++) begin
      x = sb.pop_front();
      r_beat(x.id, x.data, lasts[i], resp, ds);
      total++; if (resp !== x.resp || ds !== x.data) begin bad++; $display("FAIL rd_beat%0d: got %b/%h want %b/%h", i, resp, ds, x.resp, x.data); end
      if (i == 0) begin
        reg_rd(STAT, d, e);
        total++; if (d !== 32'hC) begin bad++; $display("FAIL rd_inject_state: got %h want c", d); end
      end
    end
    total++; if (irq !== 2'b10) begin bad++; $display("FAIL rd_irq: got %b want 10", irq); end
    reg_rd(ICNT, d, e);
    total++; if (d !== 32'h0001_0000) begin bad++; $display("FAIL rd_count: got %h want 00010000", d); end
    reg_wr(STAT, 32'h20);
  endtask

  task automatic test_atop();
    logic [31:0] d, ds;
    logic        e;
    logic [1:0]  resp;
    exp_t        x;
    reg_wr(CTRL, 32'h22);
    send_aw(2'd1, 32'h80, 6'b100000);
    sb.push_back('{id: 2'd1, resp: 2'b10, data: 32'h7777_0001});
    sb.push_back('{id: 2'd1, resp: 2'b00, data: 32'h0});
    x = sb.pop_front();
    r_beat(x.id, x.data, 1'b1, resp, ds);
    total++; if (resp !== x.resp) begin bad++; $display("FAIL atop_rresp: got %b want %b", resp, x.resp); end
    x = sb.pop_front();
    b_beat(x.id, resp);
    total++; if (resp !== x.resp) begin bad++; $display("FAIL atop_bresp: got %b want %b", resp, x.resp); end
    reg_rd(STAT, d, e);
    total++; if (d !== 32'h20) begin bad++; $display("FAIL atop_status: got %h want 20", d); end
    reg_rd(ICNT, d, e);
    total++; if (d !== 32'h0002_0000) begin bad++; $display("FAIL atop_count: got %h want 00020000", d); end
    reg_wr(STAT, 32'h20);
  endtask

  task automatic test_abort();
    logic [31:0] d;
    logic        e;
    logic [1:0]  resp;
    exp_t        x;
    reg_wr(MADDR, 32'h1000);
    reg_wr(MMASK, 32'hFFFF_F000);
    reg_wr(CTRL, 32'h9);
    send_aw(2'd0, 32'h3000, 6'd0);
    reg_rd(STAT, d, e);
    total++; if (d !== 32'h1) begin bad++; $display("FAIL abort_nomatch: got %h want 1", d); end
    reg_wr(CTRL, 32'h40);
    reg_rd(STAT, d, e);
    total++; if (d !== 32'h0) begin bad++; $display("FAIL abort_state: got %h want 0", d); end
    sb.push_back('{id: 2'd0, resp: 2'b00, data: 32'h0});
    b_beat(2'd0, resp);
    x = sb.pop_front();
    total++; if (resp !== x.resp) begin bad++; $display("FAIL abort_bresp: got %b want %b", resp, x.resp); end
    reg_rd(ICNT, d, e);
    total++; if (d !== 32'h0002_0000) begin bad++; $display("FAIL abort_count: got %h want 00020000", d); end
    reg_rd(32'h14, d, e);
    total++; if (e !== 1'b1) begin bad++; $display("FAIL bad_offset: got err %b want 1", e); end
    reg_rd(32'h06, d, e);
    total++; if (e !== 1'b1) begin bad++; $display("FAIL unaligned: got err %b want 1", e); end
  endtask

  task automatic test_abort_inject();
    logic [31:0] d, ds;
    logic        e;
    logic [1:0]  resp;
    exp_t        x;
    reg_wr(MMASK, 32'h0);
    reg_wr(CTRL, 32'h32);
    send_ar(2'd0, 32'h10, 8'd1);
    sb.push_back('{id: 2'd0, resp: 2'b11, data: 32'hB0});
    sb.push_back('{id: 2'd0, resp: 2'b00, data: 32'hB1});
    x = sb.pop_front();
    r_beat(x.id, x.data, 1'b0, resp, ds);
    total++; if (resp !== x.resp) begin bad++; $display("FAIL abinj_beat0: got %b want %b", resp, x.resp); end
    reg_wr(CTRL, 32'h40);
    x = sb.pop_front();
    r_beat(x.id, x.data, 1'b1, resp, ds);
    total++; if (resp !== x.resp) begin bad++; $display("FAIL abinj_beat1: got %b want %b", resp, x.resp); end
    reg_rd(STAT, d, e);
    total++; if (d !== 32'h0) begin bad++; $display("FAIL abinj_status: got %h want 0", d); end
    reg_rd(ICNT, d, e);
    total++; if (d !== 32'h0002_0000) begin bad++; $display("FAIL abinj_count: got %h want 00020000", d); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] d;
    logic        e;
    logic [1:0]  resp;
    exp_t        x;
    reg_wr(CTRL, 32'h9);
    sb.push_back('{id: 2'd2, resp: 2'b10, data: 32'h0});
    slv_req.aw.id    = 2'd2;
    slv_req.aw.addr  = 32'h44;
    slv_req.aw.atop  = 6'd0;
    slv_req.aw_valid = 1'b1;
    mst_rsp.b.id     = 2'd2;
    mst_rsp.b.resp   = 2'b00;
    mst_rsp.b_valid  = 1'b1;
    slv_req.b_ready  = 1'b1;
    @(negedge clk_i);
    resp = slv_rsp.b.resp;
    step();
    slv_req.aw_valid = 1'b0;
    mst_rsp.b_valid  = 1'b0;
    slv_req.b_ready  = 1'b0;
    x = sb.pop_front();
    total++; if (resp !== x.resp) begin bad++; $display("FAIL same_cycle_b: got %b want %b", resp, x.resp); end
    reg_rd(STAT, d, e);
    total++; if (d !== 32'h10) begin bad++; $display("FAIL same_cycle_status: got %h want 10", d); end
    reg_wr(CTRL, 32'h9);
    send_aw(2'd3, 32'h50, 6'd0);
    reg_wr(CTRL, 32'h9);
    reg_rd(STAT, d, e);
    total++; if (d !== 32'h12) begin bad++; $display("FAIL arm_in_wait: got %h want 12", d); end
    sb.push_back('{id: 2'd3, resp: 2'b10, data: 32'h0});
    b_beat(2'd3, resp);
    x = sb.pop_front();
    total++; if (resp !== x.resp) begin bad++; $display("FAIL arm_in_wait_b: got %b want %b", resp, x.resp); end
    reg_rd(ICNT, d, e);
    total++; if (d !== 32'h0002_0002) begin bad++; $display("FAIL b2b_count: got %h want 00020002", d); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_ni  = 1'b0;
    slv_req = '0;
    mst_rsp = '0;
    reg_req = '0;
    mst_rsp.aw_ready = 1'b1;
    mst_rsp.ar_ready = 1'b1;
    mst_rsp.w_ready  = 1'b1;
    repeat (3) @(posedge clk_i);
    #1;
    rst_ni = 1'b1;
    step();
    test_reset();
    test_write_inject();
    test_skip();
    test_read_inject();
    test_atop();
    test_abort();
    test_abort_inject();
    test_back_to_back();
    total++; if (sb.size() != 0) begin bad++; $display("FAIL scoreboard_left: got %0d want 0", sb.size()); end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
